johnson_counter_gen: RTL

Parametrised, self-correcting shift-register sequencer: the next generation of the team's 4-bit Johnson counter. It supports any width N, Johnson or ring mode, bidirectional stepping, count enable, and synchronous load. It also provides a decoded phase index, a wrap pulse and illegal-state recovery. It sits wherever glitch-free multi-phase enables or clock-phase selects are generated from a single clock domain.

---
 rtl/johnson_counter_gen.sv | 113 +++++++++++
 1 files changed

// File: rtl/johnson_counter_gen.sv
// Parametrised self-correcting shift-register sequencer.
// Johnson (2N states) or ring (N states), bidirectional, with enable,
// synchronous load, phase decode, wrap pulse and illegal-state recovery.
module johnson_counter_gen #(
    parameter int N  = 4,
    parameter int PW = $clog2(2*N)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    input  logic          dir,
    input  logic          mode,
    input  logic          load,
    input  logic [N-1:0]  load_val,
    output logic [N-1:0]  count,
    output logic [PW-1:0] phase,
    output logic          wrap,
    output logic          err,
    output logic          illegal
);

    logic [N-1:0] r_count;
    logic         r_wrap;
    logic         r_err;

    logic [N-1:0] w_seed;
    logic [N-1:0] w_step;
    int           w_ones;
    int           w_trans;
    int           w_setidx;
    logic         w_legal;

    assign count   = r_count;
    assign wrap    = r_wrap;
    assign err     = r_err;
    assign illegal = ~w_legal;

    // Seed depends on the current mode: all zeros for Johnson, MSB only for ring.
    always_comb begin
        w_seed = '0;
        if (mode) w_seed[N-1] = 1'b1;
    end

    // One step of the shift register in the requested direction.
    always_comb begin
        if (mode)
            w_step = dir ? {r_count[N-2:0], r_count[N-1]}
                         : {r_count[0], r_count[N-1:1]};
        else
            w_step = dir ? {r_count[N-2:0], ~r_count[N-1]}
                         : {~r_count[0], r_count[N-1:1]};
    end

    // Population count, adjacent-bit transitions and set-bit position of the state.
    always_comb begin
        w_ones   = 0;
        w_trans  = 0;
        w_setidx = 0;
        for (int i = 0; i < N; i++) begin
            if (r_count[i]) begin
                w_ones   = w_ones + 1;
                w_setidx = i;
            end
        end
        for (int i = 0; i < N-1; i++) begin
            if (r_count[i] != r_count[i+1]) w_trans = w_trans + 1;
        end
    end

    // Legality is judged under the current mode, so a mode change re-checks the state.
    always_comb begin
        w_legal = mode ? (w_ones == 1) : (w_trans <= 1);
    end

    // Phase = position in the dir=0 sequence; forced to 0 for illegal states.
    always_comb begin
        phase = '0;
        if (w_legal) begin
            if (mode)
                phase = PW'(N - 1 - w_setidx);
            else if (r_count[N-1] || (w_ones == 0))
                phase = PW'(w_ones);
            else
                phase = PW'(2*N - w_ones);
        end
    end

    // State update: reset > load > illegal correction > step > hold.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= w_seed;
            r_wrap  <= 1'b0;
            r_err   <= 1'b0;
        end else if (load) begin
            r_count <= load_val;
            r_wrap  <= 1'b0;
            r_err   <= 1'b0;
        end else if (!w_legal) begin
            // Recovery does not depend on en.
            r_count <= w_seed;
            r_wrap  <= 1'b0;
            r_err   <= 1'b1;
        end else if (en) begin
            r_count <= w_step;
            r_wrap  <= (w_step == w_seed);
            r_err   <= 1'b0;
        end else begin
            r_wrap  <= 1'b0;
            r_err   <= 1'b0;
        end
    end

endmodule
